// File: rtl/riscvmulti.sv
// riscvmulti: multicycle RV32I-subset core on one shared memory port,
// with illegal-instruction trap, RV32E option and perf counters.
module riscvmulti #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic             nop,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  state_t state, state_n;

  logic [31:0] old_pc, ir, a, b, alu_out, data;
  logic [31:0] rf [NREGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal;
  logic use_rd, use_rs1, use_rs2, bad_reg, legal;

  always_comb begin
    is_r = (opc == 7'b0110011) &&
           ((f7 == 7'h00 && f3 inside {3'b000, 3'b111, 3'b110, 3'b010}) ||
            (f7 == 7'h20 && f3 == 3'b000));
    is_i = (opc == 7'b0010011) &&
           (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
    is_lw  = (opc == 7'b0000011) && (f3 == 3'b010);
    is_sw  = (opc == 7'b0100011) && (f3 == 3'b010);
    is_br  = (opc == 7'b1100011) && (f3[2:1] == 2'b00);
    is_jal = (opc == 7'b1101111);
    use_rd  = is_r | is_i | is_lw | is_jal;
    use_rs1 = is_r | is_i | is_lw | is_sw | is_br;
    use_rs2 = is_r | is_sw | is_br;
    // RV32E: upper half of the register space does not exist
    bad_reg = (NREGS == 16) &&
              ((use_rd && rd[4]) || (use_rs1 && rs1[4]) ||
               (use_rs2 && rs2[4]));
    legal = (is_r | is_i | is_lw | is_sw | is_br | is_jal) && !bad_reg;
  end

  logic [31:0] opb, alu_res;
  logic        sub;

  assign opb = (state == EXEC_I) ? imm_i : b;
  assign sub = (state == EXEC_R) && (f3 == 3'b000) && f7[5];

  always_comb begin
    alu_res = a + opb;
    unique case (1'b1)
      f3 == 3'b111: alu_res = a & opb;
      f3 == 3'b110: alu_res = a | opb;
      f3 == 3'b010: alu_res = {31'd0, $signed(a) < $signed(opb)};
      sub:          alu_res = a - opb;
      default:      alu_res = a + opb;
    endcase
  end

  logic retire;

  always_comb begin
    state_n = state;
    retire  = 1'b0;
    unique case (state)
      FETCH:  if (mem_ready) state_n = DECODE;
      DECODE: begin
        if (!legal)              state_n = TRAP;
        else if (is_lw || is_sw) state_n = MEMADR;
        else if (is_r)           state_n = EXEC_R;
        else if (is_i)           state_n = EXEC_I;
        else if (is_br)          state_n = BRANCH;
        else                     state_n = JAL;
      end
      MEMADR: state_n = is_lw ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_n = MEMWB;
      MEMWR:  if (mem_ready) begin
        state_n = FETCH;
        retire  = 1'b1;
      end
      EXEC_R, EXEC_I: state_n = ALUWB;
      MEMWB, ALUWB, BRANCH, JAL: begin
        state_n = FETCH;
        retire  = 1'b1;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  assign mem_req = !reset &&
    (state == FETCH || state == MEMRD || state == MEMWR);
  assign mem_we    = !reset && (state == MEMWR);
  assign mem_addr  = (state == FETCH) ? pc : alu_out;
  assign mem_wdata = b;
  assign nop  = !reset && (state == DECODE) && (ir == 32'h0000_0013);
  assign trap = (state == TRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state     <= state_n;
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
      unique case (state)
        FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          old_pc <= pc;
          pc     <= pc + 32'd4;
        end
        DECODE: begin
          a       <= (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
          b       <= (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];
          alu_out <= old_pc + imm_b;
        end
        MEMADR: alu_out <= a + (is_lw ? imm_i : imm_s);
        MEMRD:  if (mem_ready) data <= mem_rdata;
        EXEC_R, EXEC_I: alu_out <= alu_res;
        BRANCH: if ((a == b) ^ f3[0]) pc <= alu_out;
        JAL:    pc <= old_pc + imm_j;
        default: ;
      endcase
    end
  end

  logic        rf_we;
  logic [31:0] rf_wd;

  assign rf_we = !reset && (rd != 5'd0) &&
    (state == MEMWB || state == ALUWB || state == JAL);
  assign rf_wd = (state == MEMWB) ? data :
                 (state == ALUWB) ? alu_out : pc;

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd[RW-1:0]] <= rf_wd;
  end
endmodule

// File: tb/tb_riscvmulti.sv
// Directed bench for riscvmulti: ALU, load/store with wait states,
// branches, jal, nop pulse, traps (incl. RV32E) and reset behaviour.
module tb_riscvmulti;
  logic        clk, reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        nop, trap;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        e_req, e_we, e_nop, e_trap;
  logic [31:0] e_addr, e_wdata, e_pc, e_cyc, e_ret;

  logic [31:0] mem [256];
  logic        stall;
  int          wait_n, wc;
  int          checks, errors;
  logic        data_acc;

  riscvmulti dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .nop(nop), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // RV32E core always fetches add x20,x1,x2
  riscvmulti #(.NREGS(16)) dut_e (
    .clk(clk), .reset(reset),
    .mem_req(e_req), .mem_we(e_we),
    .mem_addr(e_addr), .mem_wdata(e_wdata),
    .mem_ready(1'b1), .mem_rdata(32'h0020_8A33),
    .pc(e_pc), .nop(e_nop), .trap(e_trap),
    .cycle_cnt(e_cyc), .instret_cnt(e_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_acc  = mem_we || (mem_addr != pc);
  assign mem_ready = mem_req &&
    !(data_acc && (stall || wc < wait_n));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ready) wc <= 0;
    else wc <= wc + 1;
    if (mem_req && mem_we && mem_ready)
      mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    stall = 1'b0; wait_n = 0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0050_0093; // addi x1,x0,5
    mem[1]  = 32'h0070_0113; // addi x2,x0,7
    mem[2]  = 32'h0020_81B3; // add x3,x1,x2
    mem[3]  = 32'h4020_8233; // sub x4,x1,x2
    mem[4]  = 32'h0030_2423; // sw x3,8(x0)
    mem[5]  = 32'h0080_2283; // lw x5,8(x0)
    mem[6]  = 32'h0E80_006F; // jal x0,+232
    mem[64] = 32'h0100_00EF; // jal x1,+16
    mem[68] = 32'h0010_9463; // bne x1,x1,8
    mem[69] = 32'h0010_0333; // add x6,x0,x1
    mem[70] = 32'hFE10_8EE3; // beq x1,x1,-4

    step(1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_nop", {31'd0, nop}, 32'd0);
    step(1);
    reset = 1'b0;
    #1;
    chk("c1_pc", pc, 32'h0);
    chk("c1_req", {31'd0, mem_req}, 32'd1);
    chk("c1_cyc", cycle_cnt, 32'd0);
    chk("c1_ret", instret_cnt, 32'd0);
    chk("c1_trap", {31'd0, trap}, 32'd0);

    step(16);
    chk("x3", dut.rf[3], 32'd12);
    chk("x4", dut.rf[4], 32'hFFFF_FFFE);
    chk("alu_ret", instret_cnt, 32'd4);
    chk("alu_cyc", cycle_cnt, 32'd16);
    chk("alu_pc", pc, 32'd16);
    chk("e_trap", {31'd0, e_trap}, 32'd1);
    chk("e_req", {31'd0, e_req}, 32'd0);
    chk("e_ret", e_ret, 32'd0);
    chk("e_cyc", e_cyc, 32'd16);

    wait_n = 2;
    step(3);
    chk("sw_req", {31'd0, mem_req}, 32'd1);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_rdy", {31'd0, mem_ready}, 32'd0);
    chk("sw_addr0", mem_addr, 32'd8);
    chk("sw_wd0", mem_wdata, 32'd12);
    step(1);
    chk("sw_addr1", mem_addr, 32'd8);
    chk("sw_wd1", mem_wdata, 32'd12);
    step(5);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    chk("lw_rdy", {31'd0, mem_ready}, 32'd0);
    chk("lw_addr0", mem_addr, 32'd8);
    step(1);
    chk("lw_addr1", mem_addr, 32'd8);
    step(3);
    chk("mem8", mem[2], 32'd12);
    chk("x5", dut.rf[5], 32'd12);
    chk("ls_cyc", cycle_cnt, 32'd29);
    chk("ls_ret", instret_cnt, 32'd6);
    chk("ls_pc", pc, 32'd24);
    wait_n = 0;

    step(3);
    chk("jal0_pc", pc, 32'h100);
    chk("jal0_addr", mem_addr, 32'h100);
    chk("jal0_ret", instret_cnt, 32'd7);
    step(3);
    chk("jal1_pc", pc, 32'h110);
    chk("jal1_addr", mem_addr, 32'h110);
    chk("jal1_x1", dut.rf[1], 32'h104);
    step(3);
    chk("bne_pc", pc, 32'h114);
    chk("bne_cyc", cycle_cnt, 32'd38);
    step(4);
    chk("x0_read", dut.rf[6], 32'h104);
    step(3);
    chk("beq_pc", pc, 32'h114);
    chk("beq_ret", instret_cnt, 32'd11);
    chk("beq_cyc", cycle_cnt, 32'd45);

    reset = 1'b1;
    mem[0] = 32'h0000_0013; // nop
    mem[1] = 32'hFFFF_FFFF; // illegal
    step(1);
    chk("rst2_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_nop", {31'd0, nop}, 32'd0);
    step(1);
    reset = 1'b0;
    #1;
    chk("b1_pc", pc, 32'h0);
    chk("b1_trap", {31'd0, trap}, 32'd0);
    chk("b1_etrap", {31'd0, e_trap}, 32'd0);
    chk("b1_nop", {31'd0, nop}, 32'd0);
    step(1);
    chk("nop_on", {31'd0, nop}, 32'd1);
    step(1);
    chk("nop_off", {31'd0, nop}, 32'd0);
    step(3);
    chk("trap_dec", {31'd0, trap}, 32'd0);
    step(1);
    chk("trap_on", {31'd0, trap}, 32'd1);
    chk("trap_req", {31'd0, mem_req}, 32'd0);
    step(2);
    chk("trap_hold", {31'd0, trap}, 32'd1);
    chk("trap_req2", {31'd0, mem_req}, 32'd0);
    chk("trap_ret", instret_cnt, 32'd1);
    chk("trap_cyc", cycle_cnt, 32'd8);

    reset = 1'b1;
    mem[0] = 32'h0090_0393; // addi x7,x0,9
    mem[1] = 32'h00C0_2383; // lw x7,12(x0)
    mem[3] = 32'hDEAD_BEEF;
    step(2);
    reset = 1'b0;
    #1;
    chk("c_trap", {31'd0, trap}, 32'd0);
    chk("c_addr", mem_addr, 32'h0);
    stall = 1'b1;
    step(9);
    chk("stl_req", {31'd0, mem_req}, 32'd1);
    chk("stl_addr", mem_addr, 32'd12);
    chk("stl_x7", dut.rf[7], 32'd9);
    reset = 1'b1;
    step(1);
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_ret", instret_cnt, 32'd0);
    chk("abort_x7", dut.rf[7], 32'd9);
    stall = 1'b0;
    step(1);
    reset = 1'b0;
    #1;
    chk("rs_req", {31'd0, mem_req}, 32'd1);
    chk("rs_addr", mem_addr, 32'h0);
    step(9);
    chk("lw_x7", dut.rf[7], 32'hDEAD_BEEF);
    chk("lw_ret", instret_cnt, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/riscvmulti.md
# riscvmulti

Multicycle RV32I-subset core and the parametrised successor to the single-cycle core. It executes one instruction over 3–5 states of a controller FSM and shares one unified instruction/data memory port with a ready handshake. It sits at the top of the processor hierarchy, in place of the single-cycle core, next to a single memory model or bus bridge. It adds wait-state tolerance, an illegal-instruction trap, an RV32E register-file option and cycle/retired-instruction counters.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NREGS, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
- CNT_W, 32, width of cycle and retired-instruction counters
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = load/fetch
- mem_addr  out  32  byte address; PC during fetch, ALU result during load/store
- mem_wdata  out  32  store data (rs2)
- mem_ready  in  1  access completes in any cycle where mem_req && mem_ready
- mem_rdata  in  32  read data, valid in the completing cycle
- pc  out  32  current PC register
- nop  out  1  pulses for one cycle in DECODE when IR == 32'h0000_0013
- trap  out  1  illegal instruction seen; sticky until reset
- cycle_cnt  out  CNT_W  cycles since reset, wraps
- instret_cnt  out  CNT_W  retired instructions, wraps

## Operation
- Supported instructions: add, sub, and, or, slt; addi, andi, ori, slti; lw, sw; beq, bne; jal. Any other opcode/funct3/funct7 combination is illegal.
- RV32E: when NREGS=16, any rs1/rs2/rd index ≥ 16 is illegal. x0 always reads 0, and writes to x0 are dropped.
- Registers: PC, OldPC, IR, A, B, ALUOut, Data.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.
- FETCH: mem_req=1, mem_we=0, addr=PC. On mem_ready: IR<=rdata, OldPC<=PC, PC<=PC+4, go to DECODE. Otherwise stay in FETCH.
- DECODE: A<=rf[rs1], B<=rf[rs2], ALUOut<=OldPC+immB. Next state by opcode: lw/sw→MEMADR, R-type→EXEC_R, I-ALU→EXEC_I, branch→BRANCH, jal→JAL, illegal→TRAP.
- MEMADR: ALUOut<=A+imm (I-type imm for lw, S-type for sw). Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, we=0, addr=ALUOut. On ready: Data<=rdata, go to MEMWB.
- MEMWB: rf[rd]<=Data, retire, go to FETCH.
- MEMWR: mem_req=1, we=1, addr=ALUOut, wdata=B. On ready: retire, go to FETCH.
- EXEC_R / EXEC_I: ALUOut<=A op B or A op imm. sub uses funct7[5]; slt is signed. Go to ALUWB.
- ALUWB: rf[rd]<=ALUOut, retire, go to FETCH.
- BRANCH: if (A==B) XOR bne, then PC<=ALUOut. Retire, go to FETCH.
- JAL: rf[rd]<=PC (OldPC+4), PC<=OldPC+immJ. Retire, go to FETCH.
- TRAP: no memory requests, no register-file writes, trap=1. Stays in TRAP until reset; instret_cnt frozen, cycle_cnt keeps counting.
- "Retire" means instret_cnt increments on the clock edge that leaves the state. All adds wrap modulo 2^32, and the counters wrap modulo 2^CNT_W.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IR=0, trap=0, cycle_cnt=0, instret_cnt=0. mem_req is asserted in the first cycle after reset deasserts. Register-file contents are not reset.
- During reset: mem_req=0, nop=0.
- Reset asserted mid-access, including with mem_req high and mem_ready low, aborts the access. No write to the register file or PC other than the reset values.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.
- Outside memory states, mem_req=0 and mem_we=0.
- Cycle counts with mem_ready tied high:
  - lw: 5 cycles
  - sw, R-type, I-ALU: 4 cycles
  - branch, jal: 3 cycles
  - Each wait cycle on a memory access adds 1.
- A branch to its own address (offset 0) is legal and re-fetches the same PC.
- Register writes become visible to the next instruction's DECODE.

## Test plan
- Reset, then `addi x1,x0,5`; `addi x2,x0,7`; `add x3,x1,x2`; `sub x4,x1,x2`, zero-wait memory → x3=12 and x4=0xFFFF_FFFE, instret_cnt=4 after 16 cycles.
- `sw x3,8(x0)` then `lw x5,8(x0)`, with mem_ready low for 2 cycles on each access → mem[8]=12, x5=12, mem_addr/mem_wdata stable during the waits, total 13 cycles.
- `beq x1,x1,-4` taken → PC returns to OldPC-4. `bne x1,x1,8` not taken → PC=OldPC+4. Each takes 3 cycles.
- `jal x1,+16` at PC 0x100 → x1=0x104, next fetch address 0x110. `jal x0,...` leaves x0 reading 0.
- Instruction 0xFFFF_FFFF, or `add x20,x1,x2` with NREGS=16 → trap=1 from the cycle after DECODE, mem_req stays 0, instret_cnt frozen. reset clears trap and restarts fetch at RESET_PC.
- `addi x0,x0,0` → nop pulses for exactly 1 cycle. Reset asserted during a stalled lw → PC=RESET_PC, no register-file write.
